// File: rtl/dcache_pkg.sv
// Shared widths, FSM state type and address field helpers for the data-cache controller.
package dcache_pkg;

    localparam int ADDR_W      = 32;
    localparam int WORD_W      = 32;
    localparam int WORD_BYTES  = WORD_W / 8;
    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_W     = 8 * BLOCK_BYTES;
    localparam int OFF_W       = $clog2(BLOCK_BYTES);
    localparam int INDEX_W     = 6;
    localparam int TAG_W       = ADDR_W - INDEX_W - OFF_W;
    localparam int BLK_ADDR_W  = TAG_W + INDEX_W;
    localparam int BLOCK_WORDS = BLOCK_BYTES / WORD_BYTES;
    localparam int WSEL_W      = $clog2(BLOCK_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WB,
        REFILL,
        FILL
    } state_e;

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: INDEX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W-1:0];
    endfunction

    // {tag, index}: the line address as the SRAM array and memory see it.
    function automatic logic [BLK_ADDR_W-1:0] addr_block(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:OFF_W];
    endfunction

endpackage

// File: rtl/dcache_word_sel.sv
// Offset-driven word extraction from a cache line and byte-enable placement into a line mask.
module dcache_word_sel
    import dcache_pkg::*;
(
    input  logic [OFF_W-1:0]       off_i,
    input  logic [BLOCK_W-1:0]     line_i,
    input  logic [WORD_BYTES-1:0]  be_i,
    output logic [WORD_W-1:0]      word_o,
    output logic [BLOCK_BYTES-1:0] bytes_o
);

    localparam int BSEL_W = $clog2(WORD_BYTES);

    logic [WSEL_W-1:0] word_idx;

    assign word_idx = off_i[OFF_W-1:BSEL_W];
    assign word_o   = line_i[word_idx*WORD_W +: WORD_W];
    // Addresses are word aligned, so the byte offset is already a multiple of WORD_BYTES.
    assign bytes_o  = BLOCK_BYTES'(be_i) << off_i;

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate D-cache controller: hit/miss resolution, victim writeback, refill, fill.
// Define DCACHE_CTRL_PERF_EN to add saturating hit/miss/writeback counters.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_ren_i,
    input  logic                   cpu_wen_i,
    input  logic [ADDR_W-1:0]      cpu_addr_i,
    input  logic [WORD_W-1:0]      cpu_wdata_i,
    input  logic [WORD_BYTES-1:0]  cpu_be_i,
    output logic [WORD_W-1:0]      cpu_rdata_o,
    output logic                   cpu_stall_o,
    output logic                   sram_ren_o,
    output logic                   sram_wen_o,
    output logic                   sram_mem_wen_o,
    output logic [BLK_ADDR_W-1:0]  sram_block_addr_o,
    output logic [BLOCK_BYTES-1:0] sram_bytes_o,
    output logic [BLOCK_W-1:0]     sram_wdata_o,
    input  logic                   sram_hit_i,
    input  logic                   sram_dirty_i,
    input  logic [BLOCK_W-1:0]     sram_rdata_i,
    input  logic [TAG_W-1:0]       sram_victim_tag_i,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [BLOCK_W-1:0]     mem_wdata_o,
    input  logic [BLOCK_W-1:0]     mem_rdata_i,
    input  logic                   mem_ack_i
`ifdef DCACHE_CTRL_PERF_EN
    ,
    output logic [31:0]            perf_hits_o,
    output logic [31:0]            perf_misses_o,
    output logic [31:0]            perf_wbs_o
`endif
);

    state_e                 state_q, state_d;
    logic [BLOCK_W-1:0]     victim_line_q, victim_line_d;
    logic [BLK_ADDR_W-1:0]  victim_blk_q, victim_blk_d;
    logic [BLOCK_W-1:0]     refill_q, refill_d;
    logic                   gap_q, gap_d;

    logic                   req;
    logic [BLK_ADDR_W-1:0]  req_blk;
    logic [OFF_W-1:0]       req_off;
    logic [WORD_W-1:0]      sel_word;
    logic [BLOCK_BYTES-1:0] sel_bytes;

    assign req     = cpu_ren_i | cpu_wen_i;
    assign req_blk = addr_block(cpu_addr_i);
    assign req_off = addr_off(cpu_addr_i);

    dcache_word_sel u_word_sel (
        .off_i   (req_off),
        .line_i  (sram_rdata_i),
        .be_i    (cpu_be_i),
        .word_o  (sel_word),
        .bytes_o (sel_bytes)
    );

    // NOTE: the line buffers are reset along with the state; they drive output data buses directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            victim_line_q <= '0;
            victim_blk_q  <= '0;
            refill_q      <= '0;
            gap_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q       <= state_d;
            victim_line_q <= victim_line_d;
            victim_blk_q  <= victim_blk_d;
            refill_q      <= refill_d;
            gap_q         <= gap_d;
        end
    end

    always_comb begin
        // NOTE: every output and next-state is defaulted first so no path infers a latch.
        state_d           = state_q;
        victim_line_d     = victim_line_q;
        victim_blk_d      = victim_blk_q;
        refill_d          = refill_q;
        gap_d             = 1'b0;
        cpu_rdata_o       = '0;
        cpu_stall_o       = 1'b0;
        sram_ren_o        = 1'b0;
        sram_wen_o        = 1'b0;
        sram_mem_wen_o    = 1'b0;
        sram_block_addr_o = '0;
        sram_bytes_o      = '0;
        sram_wdata_o      = '0;
        mem_req_o         = 1'b0;
        mem_we_o          = 1'b0;
        mem_addr_o        = '0;
        mem_wdata_o       = '0;

        if (rst) begin
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        sram_ren_o        = cpu_ren_i & ~cpu_wen_i;
                        sram_wen_o        = cpu_wen_i & sram_hit_i;
                        sram_block_addr_o = req_blk;
                        if (sram_hit_i) begin
                            if (cpu_wen_i) begin
                                sram_bytes_o = sel_bytes;
                                sram_wdata_o = {BLOCK_WORDS{cpu_wdata_i}};
                            end else begin
                                cpu_rdata_o = sel_word;
                            end
                        end else begin
                            cpu_stall_o   = 1'b1;
                            victim_line_d = sram_rdata_i;
                            victim_blk_d  = {sram_victim_tag_i, addr_index(cpu_addr_i)};
                            state_d       = sram_dirty_i ? WB : REFILL;
                        end
                    end
                end
                WB: begin
                    cpu_stall_o = 1'b1;
                    mem_req_o   = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = {victim_blk_q, {OFF_W{1'b0}}};
                    mem_wdata_o = victim_line_q;
                    if (mem_ack_i) begin
                        gap_d   = 1'b1;
                        state_d = REFILL;
                    end
                end
                REFILL: begin
                    // After a writeback the request is dropped for one cycle before the read starts.
                    cpu_stall_o = 1'b1;
                    mem_req_o   = ~gap_q;
                    mem_addr_o  = {req_blk, {OFF_W{1'b0}}};
                    if (mem_ack_i && !gap_q) begin
                        refill_d = mem_rdata_i;
                        state_d  = FILL;
                    end
                end
                FILL: begin
                    cpu_stall_o       = 1'b1;
                    sram_mem_wen_o    = 1'b1;
                    sram_block_addr_o = req_blk;
                    sram_bytes_o      = '1;
                    sram_wdata_o      = refill_q;
                    state_d           = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef DCACHE_CTRL_PERF_EN
    logic        hit_evt, miss_evt, wb_evt;
    logic [31:0] hits_q, misses_q, wbs_q;

    assign hit_evt  = (state_q == IDLE) && req && sram_hit_i;
    assign miss_evt = (state_q == IDLE) && req && !sram_hit_i;
    assign wb_evt   = (state_q == WB) && mem_ack_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hits_q   <= '0;
            misses_q <= '0;
            wbs_q    <= '0;
        end else begin
            if (hit_evt && !(&hits_q))    hits_q   <= hits_q + 32'd1;
            if (miss_evt && !(&misses_q)) misses_q <= misses_q + 32'd1;
            if (wb_evt && !(&wbs_q))      wbs_q    <= wbs_q + 32'd1;
        end
    end

    assign perf_hits_o   = hits_q;
    assign perf_misses_o = misses_q;
    assign perf_wbs_o    = wbs_q;
`endif

    a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
        cpu_stall_o |=> $stable(cpu_addr_i));

    a_strobe_excl: assert property (@(posedge clk)
        $onehot0({sram_ren_o, sram_wen_o, sram_mem_wen_o}));

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a direct-mapped SRAM array model and a fixed-latency memory.
module tb_dcache_ctrl;

    localparam int MEM_LAT = 3;
    localparam int BUDGET  = 64;

    logic          clk;
    logic          rst;
    logic          cpu_ren_i, cpu_wen_i;
    logic [31:0]   cpu_addr_i, cpu_wdata_i;
    logic [3:0]    cpu_be_i;
    logic [31:0]   cpu_rdata_o;
    logic          cpu_stall_o;
    logic          sram_ren_o, sram_wen_o, sram_mem_wen_o;
    logic [27:0]   sram_block_addr_o;
    logic [15:0]   sram_bytes_o;
    logic [127:0]  sram_wdata_o;
    logic          sram_hit_i, sram_dirty_i;
    logic [127:0]  sram_rdata_i;
    logic [21:0]   sram_victim_tag_i;
    logic          mem_req_o, mem_we_o;
    logic [31:0]   mem_addr_o;
    logic [127:0]  mem_wdata_o, mem_rdata_i;
    logic          mem_ack_i;
`ifdef DCACHE_CTRL_PERF_EN
    logic [31:0]   perf_hits_o, perf_misses_o, perf_wbs_o;
`endif

    dcache_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_ren_i         (cpu_ren_i),
        .cpu_wen_i         (cpu_wen_i),
        .cpu_addr_i        (cpu_addr_i),
        .cpu_wdata_i       (cpu_wdata_i),
        .cpu_be_i          (cpu_be_i),
        .cpu_rdata_o       (cpu_rdata_o),
        .cpu_stall_o       (cpu_stall_o),
        .sram_ren_o        (sram_ren_o),
        .sram_wen_o        (sram_wen_o),
        .sram_mem_wen_o    (sram_mem_wen_o),
        .sram_block_addr_o (sram_block_addr_o),
        .sram_bytes_o      (sram_bytes_o),
        .sram_wdata_o      (sram_wdata_o),
        .sram_hit_i        (sram_hit_i),
        .sram_dirty_i      (sram_dirty_i),
        .sram_rdata_i      (sram_rdata_i),
        .sram_victim_tag_i (sram_victim_tag_i),
        .mem_req_o         (mem_req_o),
        .mem_we_o          (mem_we_o),
        .mem_addr_o        (mem_addr_o),
        .mem_wdata_o       (mem_wdata_o),
        .mem_rdata_i       (mem_rdata_i),
        .mem_ack_i         (mem_ack_i)
`ifdef DCACHE_CTRL_PERF_EN
        ,
        .perf_hits_o       (perf_hits_o),
        .perf_misses_o     (perf_misses_o),
        .perf_wbs_o        (perf_wbs_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Direct-mapped SRAM array model: combinational lookup, writes at the clock edge.
    logic         sv_valid [64] = '{default: 1'b0};
    logic         sv_dirty [64] = '{default: 1'b0};
    logic [21:0]  sv_tag   [64] = '{default: 22'h0};
    logic [127:0] sv_data  [64] = '{default: 128'h0};
    int           n_fill = 0;
    logic [5:0]   s_idx;
    logic [21:0]  s_tag;

    assign s_idx             = sram_block_addr_o[5:0];
    assign s_tag             = sram_block_addr_o[27:6];
    assign sram_hit_i        = sv_valid[s_idx] && (sv_tag[s_idx] == s_tag);
    assign sram_dirty_i      = sv_dirty[s_idx];
    assign sram_rdata_i      = sv_data[s_idx];
    assign sram_victim_tag_i = sv_tag[s_idx];

    always @(posedge clk) begin
        if (sram_wen_o) begin
            for (int b = 0; b < 16; b++)
                if (sram_bytes_o[b]) sv_data[s_idx][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            sv_dirty[s_idx] <= 1'b1;
        end
        if (sram_mem_wen_o) begin
            sv_data[s_idx]  <= sram_wdata_o;
            sv_tag[s_idx]   <= s_tag;
            sv_valid[s_idx] <= 1'b1;
            sv_dirty[s_idx] <= 1'b0;
            n_fill          <= n_fill + 1;
        end
    end

    // Memory: acks in the MEM_LAT-th consecutive cycle of a request; default word = 0x1000_0000 + address.
    logic [127:0] mem_lines [logic [31:0]];
    logic [32:0]  txn_log [$];
    int           n_rd = 0, n_wr = 0, req_cnt = 0;

    function automatic logic [127:0] mem_line(input logic [31:0] line_addr);
        logic [127:0] l;
        if (mem_lines.exists(line_addr)) return mem_lines[line_addr];
        for (int w = 0; w < 4; w++) l[32*w +: 32] = 32'h1000_0000 + line_addr + 32'(4*w);
        return l;
    endfunction

    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            #2;
            mem_ack_i = 1'b0;
            if (mem_req_o) begin
                req_cnt++;
                if (req_cnt == MEM_LAT) begin
                    req_cnt   = 0;
                    mem_ack_i = 1'b1;
                    txn_log.push_back({mem_we_o, mem_addr_o});
                    if (mem_we_o) begin
                        mem_lines[mem_addr_o] = mem_wdata_o;
                        n_wr++;
                    end else begin
                        mem_rdata_i = mem_line(mem_addr_o);
                        n_rd++;
                    end
                end
            end else begin
                req_cnt = 0;
            end
        end
    end

    int n_total = 0, n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else             n_pass++;
    endtask

    int           n_stall;
    logic [31:0]  obs_rdata;
    logic [15:0]  obs_bytes;
    logic         obs_ren, obs_wen;
    int           rd0, wr0, fill0, log0;

    task automatic snap();
        rd0   = n_rd;
        wr0   = n_wr;
        fill0 = n_fill;
        log0  = txn_log.size();
    endtask

    // Presents one request and waits (bounded) for the cycle where it completes.
    task automatic access(input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        @(negedge clk);
        cpu_ren_i   = ren;
        cpu_wen_i   = wen;
        cpu_addr_i  = addr;
        cpu_wdata_i = wdata;
        cpu_be_i    = be;
        #1;
        n_stall = 0;
        while (cpu_stall_o && n_stall < BUDGET) begin
            @(negedge clk);
            #1;
            n_stall++;
        end
        check("stall_released", cpu_stall_o, 1'b0);
        obs_rdata = cpu_rdata_o;
        obs_bytes = sram_bytes_o;
        obs_ren   = sram_ren_o;
        obs_wen   = sram_wen_o;
    endtask

    task automatic go_idle();
        @(negedge clk);
        cpu_ren_i = 1'b0;
        cpu_wen_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        cpu_ren_i   = 1'b1;
        cpu_wen_i   = 1'b0;
        cpu_addr_i  = 32'h40;
        cpu_wdata_i = '0;
        cpu_be_i    = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", cpu_stall_o, 1'b0);
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_strobes", {sram_ren_o, sram_wen_o, sram_mem_wen_o}, 3'b000);
        check("rst_rdata", cpu_rdata_o, 32'h0);
        @(negedge clk);
        cpu_ren_i = 1'b0;
        rst       = 1'b1;

        // Cold load: clean miss, 3-cycle memory -> 5 stall cycles.
        snap();
        access(1'b1, 1'b0, 32'h40, '0, '0);
        check("cold_stalls", n_stall, 5);
        check("cold_reads", n_rd - rd0, 1);
        check("cold_writes", n_wr - wr0, 0);
        check("cold_rd_addr", txn_log[log0], {1'b0, 32'h40});
        check("cold_fills", n_fill - fill0, 1);
        check("cold_rdata", obs_rdata, 32'h1000_0040);

        // Store hit, then merged read-back.
        access(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, 4'b0011);
        check("st_stalls", n_stall, 0);
        check("st_bytes", obs_bytes, 16'h0030);
        check("st_wen", obs_wen, 1'b1);
        access(1'b1, 1'b0, 32'h44, '0, '0);
        check("ld44_stalls", n_stall, 0);
        check("ld44_rdata", obs_rdata, 32'h1000_BEEF);

        // Dirty conflict miss: writeback of 0x40, then read of 0x440.
        snap();
        access(1'b1, 1'b0, 32'h440, '0, '0);
        check("dirty_stalls", n_stall, 9);
        check("dirty_writes", n_wr - wr0, 1);
        check("dirty_reads", n_rd - rd0, 1);
        check("dirty_first", txn_log[log0], {1'b1, 32'h40});
        check("dirty_second", txn_log[log0+1], {1'b0, 32'h440});
        check("dirty_wb_word", mem_line(32'h40), 128'h1000004C_10000048_1000BEEF_10000040);
        check("dirty_rdata", obs_rdata, 32'h1000_0440);

        // Clean conflict miss: no writeback.
        snap();
        access(1'b1, 1'b0, 32'h840, '0, '0);
        check("clean_stalls", n_stall, 5);
        check("clean_writes", n_wr - wr0, 0);
        check("clean_rd_addr", txn_log[log0], {1'b0, 32'h840});
        check("clean_rdata", obs_rdata, 32'h1000_0840);

        // Load and store together on a hit behave as a store.
        access(1'b1, 1'b1, 32'h848, 32'h1234_5678, 4'b1111);
        check("both_stalls", n_stall, 0);
        check("both_ren", obs_ren, 1'b0);
        check("both_wen", obs_wen, 1'b1);
        check("both_bytes", obs_bytes, 16'h0F00);
        access(1'b1, 1'b0, 32'h848, '0, '0);
        check("both_rdata", obs_rdata, 32'h1234_5678);

`ifdef DCACHE_CTRL_PERF_EN
        go_idle();
        #1;
        check("perf_hits", perf_hits_o, 32'd7);
        check("perf_misses", perf_misses_o, 32'd3);
        check("perf_wbs", perf_wbs_o, 32'd1);
`endif

        // Reset while refilling abandons the transfer.
        snap();
        @(negedge clk);
        cpu_ren_i  = 1'b1;
        cpu_wen_i  = 1'b0;
        cpu_addr_i = 32'h100;
        #1;
        check("abort_miss_stall", cpu_stall_o, 1'b1);
        @(negedge clk);
        #1;
        check("abort_in_refill", {mem_req_o, mem_we_o}, 2'b10);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_req", mem_req_o, 1'b0);
        check("abort_stall", cpu_stall_o, 1'b0);
        @(negedge clk);
        rst       = 1'b1;
        cpu_ren_i = 1'b0;
        #1;
        check("abort_idle", {cpu_stall_o, mem_req_o, sram_ren_o, sram_mem_wen_o}, 4'b0000);
        check("abort_no_txn", txn_log.size() - log0, 0);
        access(1'b1, 1'b0, 32'h100, '0, '0);
        check("restart_stalls", n_stall, 5);
        check("restart_rdata", obs_rdata, 32'h1000_0100);
        check("restart_reads", n_rd - rd0, 1);

`ifdef DCACHE_CTRL_PERF_EN
        go_idle();
        #1;
        check("perf2_hits", perf_hits_o, 32'd1);
        check("perf2_misses", perf_misses_o, 32'd1);
        check("perf2_wbs", perf_wbs_o, 32'd0);
`endif

        go_idle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
